// File: rtl/ts_cc_multi_pid_monitor_if.sv
// Byte-stream bundle feeding the CC monitor: a byte qualifier, a packet-start marker and the data byte.
interface ts_cc_multi_pid_monitor_if;
    logic       valid;
    logic       sync;
    logic [7:0] ts_data;

    modport master (output valid, output sync, output ts_data);
    modport slave  (input  valid, input  sync, input  ts_data);
endinterface

// File: rtl/ts_cc_multi_pid_monitor.sv
// Multi-PID continuity-counter monitor for an aligned MPEG-2 TS byte stream, with a self-learning
// PID table, saturating per-slot/total error counters and a registered slot read port.
module ts_cc_multi_pid_monitor #(
    parameter int NUM_PIDS    = 8,
    parameter int CNT_W       = 16,
    parameter int IGNORE_NULL = 1,
    localparam int SLOT_W     = $clog2(NUM_PIDS)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    ts_cc_multi_pid_monitor_if.slave    ts,
    input  logic                        clr_counts,
    input  logic                        clr_table,
    input  logic [SLOT_W-1:0]           rd_slot,
    output logic [12:0]                 rd_pid,
    output logic                        rd_used,
    output logic [CNT_W-1:0]            rd_count,
    output logic [CNT_W-1:0]            err_total,
    output logic [CNT_W-1:0]            tei_count,
    output logic                        err_pulse,
    output logic [SLOT_W-1:0]           err_slot,
    output logic                        table_full,
    output logic                        miss_pulse
);

    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, CHECK = 2'd2} state_t;

    localparam logic [SLOT_W:0] NUM_PIDS_L = (SLOT_W+1)'(NUM_PIDS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Lowest set bit wins, so allocation always takes the lowest free slot.
    function automatic logic [SLOT_W-1:0] lowest_idx(input logic [NUM_PIDS-1:0] v);
        logic [SLOT_W-1:0] idx;
        idx = {SLOT_W{1'b0}};
        for (int i = NUM_PIDS - 1; i >= 0; i--) begin
            if (v[i]) idx = SLOT_W'(i);
        end
        return idx;
    endfunction

    state_t                state_r, state_nxt_s;
    logic [1:0]            idx_r, idx_nxt_s;
    logic                  tei_r;
    logic [12:0]           pid_r;
    logic [1:0]            afc_r;
    logic [3:0]            cc_r;

    logic [NUM_PIDS-1:0]   used_r, used_nxt_s, dup_r, match_s;
    logic [12:0]           pid_tab_r [NUM_PIDS];
    logic [3:0]            cc_tab_r  [NUM_PIDS];
    logic [CNT_W-1:0]      cnt_r     [NUM_PIDS];

    logic                  hit_s, free_any_s, clr_any_s, act_s, eligible_s;
    logic [SLOT_W-1:0]     hit_slot_s, free_slot_s;
    logic [3:0]            p_s;
    logic                  cc_err_s, dup_nxt_s;
    logic                  do_tei_s, do_check_s, do_alloc_s, do_miss_s, do_err_s;

    logic [CNT_W-1:0]      err_total_r, tei_count_r;
    logic                  err_pulse_r, miss_pulse_r, table_full_r, rd_used_r;
    logic [SLOT_W-1:0]     err_slot_r;
    logic [12:0]           rd_pid_r;
    logic [CNT_W-1:0]      rd_count_r;
    logic                  unused_bits_s;

    assign unused_bits_s = ^{ts.ts_data[6:5], ts.ts_data[7:6]};
    assign clr_any_s     = clr_counts | clr_table;

    // State register for the header parser.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Next-state logic; a sync byte always restarts header collection at byte 1.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (ts.valid && ts.sync) begin
                    state_nxt_s = HDR;
                    idx_nxt_s   = 2'd1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HDR: begin
                if (ts.valid && ts.sync) begin
                    idx_nxt_s = 2'd1;
                end else if (ts.valid && (idx_r == 2'd3)) begin
                    state_nxt_s = CHECK;
                    idx_nxt_s   = 2'd0;
                end else if (ts.valid) begin
                    idx_nxt_s = idx_r + 2'd1;
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            CHECK: begin
                if (ts.valid && ts.sync) begin
                    state_nxt_s = HDR;
                    idx_nxt_s   = 2'd1;
                end else begin
                    state_nxt_s = IDLE;
                    idx_nxt_s   = 2'd0;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = 2'd0;
            end
        endcase
    end

    // Header field capture from bytes 1..3.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tei_r <= 1'b0;
            pid_r <= 13'd0;
            afc_r <= 2'b00;
            cc_r  <= 4'd0;
        end else if ((state_r == HDR) && ts.valid && !ts.sync) begin
            case (idx_r)
                2'd1: begin
                    tei_r       <= ts.ts_data[7];
                    pid_r[12:8] <= ts.ts_data[4:0];
                end
                2'd2:    pid_r[7:0] <= ts.ts_data;
                2'd3: begin
                    afc_r <= ts.ts_data[5:4];
                    cc_r  <= ts.ts_data[3:0];
                end
                default: pid_r <= pid_r;
            endcase
        end
    end

    // PID lookup and the packet decision taken in the CHECK cycle.
    always_comb begin
        for (int i = 0; i < NUM_PIDS; i++) begin
            match_s[i] = used_r[i] && (pid_tab_r[i] == pid_r);
        end
        hit_s       = |match_s;
        hit_slot_s  = lowest_idx(match_s);
        free_any_s  = ~&used_r;
        free_slot_s = lowest_idx(~used_r);
        p_s         = cc_tab_r[hit_slot_s];

        act_s      = (state_r == CHECK) && !clr_any_s;
        do_tei_s   = act_s && tei_r;
        eligible_s = act_s && !tei_r && (afc_r != 2'b00)
                     && !((IGNORE_NULL != 0) && (pid_r == 13'h1FFF));
        do_check_s = eligible_s && hit_s;
        do_alloc_s = eligible_s && !hit_s && free_any_s;
        do_miss_s  = eligible_s && !hit_s && !free_any_s;

        cc_err_s  = 1'b0;
        dup_nxt_s = dup_r[hit_slot_s];
        if (afc_r == 2'b10) begin
            cc_err_s = (cc_r != p_s);
        end else if (cc_r == (p_s + 4'd1)) begin
            dup_nxt_s = 1'b0;
        end else if ((cc_r == p_s) && !dup_r[hit_slot_s]) begin
            dup_nxt_s = 1'b1;
        end else begin
            cc_err_s  = 1'b1;
            dup_nxt_s = 1'b0;
        end
        do_err_s = do_check_s && cc_err_s;

        if (clr_table) begin
            used_nxt_s = {NUM_PIDS{1'b0}};
        end else if (do_alloc_s) begin
            used_nxt_s = used_r | (NUM_PIDS'(1) << free_slot_s);
        end else begin
            used_nxt_s = used_r;
        end
    end

    // PID table: allocation, stored CC / duplicate flag, and table clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            used_r       <= {NUM_PIDS{1'b0}};
            dup_r        <= {NUM_PIDS{1'b0}};
            table_full_r <= 1'b0;
            for (int i = 0; i < NUM_PIDS; i++) begin
                pid_tab_r[i] <= 13'd0;
                cc_tab_r[i]  <= 4'd0;
            end
        end else begin
            used_r       <= used_nxt_s;
            table_full_r <= &used_nxt_s;
            for (int i = 0; i < NUM_PIDS; i++) begin
                if (clr_table) begin
                    pid_tab_r[i] <= 13'd0;
                    cc_tab_r[i]  <= 4'd0;
                    dup_r[i]     <= 1'b0;
                end else if (do_check_s && (hit_slot_s == SLOT_W'(i))) begin
                    cc_tab_r[i] <= cc_r;
                    dup_r[i]    <= dup_nxt_s;
                end else if (do_alloc_s && (free_slot_s == SLOT_W'(i))) begin
                    pid_tab_r[i] <= pid_r;
                    cc_tab_r[i]  <= cc_r;
                    dup_r[i]     <= 1'b0;
                end else begin
                    cc_tab_r[i] <= cc_tab_r[i];
                end
            end
        end
    end

    // Saturating error and TEI counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_total_r <= {CNT_W{1'b0}};
            tei_count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < NUM_PIDS; i++) cnt_r[i] <= {CNT_W{1'b0}};
        end else if (clr_any_s) begin
            err_total_r <= {CNT_W{1'b0}};
            tei_count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < NUM_PIDS; i++) cnt_r[i] <= {CNT_W{1'b0}};
        end else begin
            if (do_err_s) err_total_r <= sat_inc(err_total_r);
            if (do_tei_s) tei_count_r <= sat_inc(tei_count_r);
            for (int i = 0; i < NUM_PIDS; i++) begin
                if (do_err_s && (hit_slot_s == SLOT_W'(i))) cnt_r[i] <= sat_inc(cnt_r[i]);
            end
        end
    end

    // Event pulses and last-error slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_pulse_r  <= 1'b0;
            miss_pulse_r <= 1'b0;
            err_slot_r   <= {SLOT_W{1'b0}};
        end else begin
            err_pulse_r  <= do_err_s;
            miss_pulse_r <= do_miss_s;
            if (do_err_s) err_slot_r <= hit_slot_s;
        end
    end

    // Registered slot read port; indices past the table read as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pid_r   <= 13'd0;
            rd_used_r  <= 1'b0;
            rd_count_r <= {CNT_W{1'b0}};
        end else if ({1'b0, rd_slot} < NUM_PIDS_L) begin
            rd_pid_r   <= pid_tab_r[rd_slot];
            rd_used_r  <= used_r[rd_slot];
            rd_count_r <= cnt_r[rd_slot];
        end else begin
            rd_pid_r   <= 13'd0;
            rd_used_r  <= 1'b0;
            rd_count_r <= {CNT_W{1'b0}};
        end
    end

    assign rd_pid     = rd_pid_r;
    assign rd_used    = rd_used_r;
    assign rd_count   = rd_count_r;
    assign err_total  = err_total_r;
    assign tei_count  = tei_count_r;
    assign err_pulse  = err_pulse_r;
    assign err_slot   = err_slot_r;
    assign table_full = table_full_r;
    assign miss_pulse = miss_pulse_r;

endmodule

// File: doc/ts_cc_multi_pid_monitor.md
# ts_cc_multi_pid_monitor

Parametrised continuity-counter (CC) monitor for an MPEG-2 TS byte stream, tracking up to NUM_PIDS PIDs concurrently in a self-learning PID table. Parses the 4-byte TS header, checks each PID's CC sequence per ISO/IEC 13818-1 rules, including single-duplicate tolerance, and keeps saturating per-PID and total error counters. Sits after the sync/alignment stage in the QoS path, beside the single-stream loss counter, and feeds the QoS register file through a slot read port.

## Interface
- NUM_PIDS, 8: PID table slots, at least 2; SLOT_W = $clog2(NUM_PIDS).
- CNT_W, 16: width of every error counter.
- IGNORE_NULL, 1: when 1, PID 0x1FFF is never learned or checked.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- valid  in  1  ts_data byte qualifier.
- sync  in  1  marks byte 0 (0x47) of a packet; meaningful only with valid.
- ts_data  in  8  stream byte.
- clr_counts  in  1  synchronous; zeroes all error counters and tei_count.
- clr_table  in  1  synchronous; invalidates all slots and also zeroes all counters.
- rd_slot  in  SLOT_W  slot select for the read port.
- rd_pid  out  13  PID in rd_slot, registered.
- rd_used  out  1  slot rd_slot is allocated, registered.
- rd_count  out  CNT_W  error count of rd_slot, registered.
- err_total  out  CNT_W  saturating total CC errors.
- tei_count  out  CNT_W  saturating count of packets with TEI=1.
- err_pulse  out  1  one-cycle pulse per detected CC error.
- err_slot  out  SLOT_W  slot of the last error; valid with err_pulse.
- table_full  out  1  all slots allocated.
- miss_pulse  out  1  one-cycle pulse when a new PID is dropped because the table is full.

## Operation
- FSM states: IDLE, HDR, CHECK.
- IDLE: waits for valid&&sync, then HDR with byte_idx=1.
- HDR: on each valid byte:
  - byte 1 captures TEI=ts_data[7] and PID[12:8]=ts_data[4:0].
  - byte 2 captures PID[7:0].
  - byte 3 captures AFC=ts_data[5:4] and CC=ts_data[3:0], then goes to CHECK.
  - valid low stalls the FSM.
  - valid&&sync in HDR restarts at byte_idx=1; the partial header is discarded.
- CHECK lasts exactly one cycle, independent of valid. Actions are evaluated in this order:
  - TEI=1: tei_count++; no table action.
  - Null PID with IGNORE_NULL=1, or AFC=00: no action.
  - PID hit in a used slot: CC rules below.
  - Miss with a free slot: allocate the lowest-index free slot, store PID and CC, clear dup; no error.
  - Miss with the table full: miss_pulse; no error.
- CHECK exit: goes to HDR (byte_idx=1) if valid&&sync in the same cycle, else IDLE.
- CC rules, with p = stored CC:
  - AFC=10: CC==p is OK; otherwise error.
  - AFC=01/11: CC==p+1 mod 16 is OK and clears dup.
  - AFC=01/11: CC==p with dup=0 is an OK duplicate and sets dup.
  - AFC=01/11: any other CC is an error and clears dup.
  - Stored CC is updated to CC in every case.
- On error: slot counter and err_total each increment by 1, saturating at 2^CNT_W-1 with no wrap. err_pulse=1 and err_slot=slot.
- Clears:
  - clr_table or clr_counts asserted on a CHECK edge wins over that edge's update, and no pulse is produced.
  - clr_table also zeroes used, PID and dup for all slots.
  - Neither clear affects the FSM.
- Read port: rd_pid, rd_used and rd_count are registered copies of slot rd_slot. rd_slot ≥ NUM_PIDS reads as zeros.

## Timing
- Reset values:
  - State IDLE.
  - All slots unused, PID/CC/dup 0.
  - All counters 0.
  - err_pulse=0, miss_pulse=0, err_slot=0, table_full=0.
  - rd_pid=0, rd_used=0, rd_count=0.
- Byte 3 accepted at edge E: CHECK is the cycle after E.
- Counters, err_pulse, miss_pulse and table_full update at edge E+1. They are visible 2 cycles after byte 3 is presented.
- err_pulse and miss_pulse are high for exactly one cycle per packet.
- Read-port latency: 1 cycle after rd_slot changes. A counter update at edge E+1 appears on rd_count at edge E+2.
- reset_n low mid-packet: immediate return to reset values. The next packet is processed only from the next valid&&sync.
- Minimum supported packet spacing: 4 bytes (header only). Back-to-back sync in the CHECK cycle is legal and is not lost.

## Test plan
- PID 0x100 with CC 0..15,0,1 (AFC=01), 18 packets → err_total=0; slot 0 used; rd_pid=0x100.
- PID 0x100 with CC 3,4,6 → one err_pulse with err_slot=0, 2 cycles after the third packet's byte 3; err_total=1.
- CC 5,5,6 → no error (single duplicate). CC 5,5,5 → exactly 1 error.
- NUM_PIDS=2; PIDs 0x10,0x20,0x30 → table_full=1 after the second packet; miss_pulse on the third; 0x1FFF never allocated; AFC=10 packet with CC unchanged → no error.
- CNT_W=4, 20 injected errors → err_total holds at 15. clr_counts coincident with an error CHECK → err_total=0 and no err_pulse. TEI=1 packet → tei_count=1 and stored CC unchanged.
- sync mid-header after byte 1, and reset_n pulsed mid-packet → partial header discarded; no spurious error; the next full packet checks normally.
